// File: rtl/sap_core_param.sv
// sap_core_param: width-generic SAP-1 style core (fetch/execute FSM, RAM, host program-load port).
// Optional single-step control (step_mode/step inputs, PAUSE state) is enabled by defining SAP_CORE_STEP_EN.
module sap_core_param #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              run,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
`ifdef SAP_CORE_STEP_EN
   input  logic              step_mode,
   input  logic              step,
`endif
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              halted,
   output logic [ADDR_W-1:0] pc_dbg
);

   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_STA = 4'h3;
   localparam logic [3:0] OP_LDI = 4'h4;
   localparam logic [3:0] OP_JMP = 4'h5;
   localparam logic [3:0] OP_JC  = 4'h6;
   localparam logic [3:0] OP_JZ  = 4'h7;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_F1    = 3'd1,
      S_F2    = 3'd2,
      S_E1    = 3'd3,
      S_E2    = 3'd4,
      S_HALT  = 3'd5
`ifdef SAP_CORE_STEP_EN
      , S_PAUSE = 3'd6
`endif
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] mar_q;
   logic [DATA_W-1:0] ir_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] out_q;
   logic              c_q;
   logic              z_q;
   logic              out_valid_q;
   logic              halted_q;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [DATA_W-1:0] ram_rd;
   logic [3:0]        opcode;
   logic [ADDR_W-1:0] operand;
   logic [DATA_W-1:0] imm;
   logic [DATA_W:0]   add_res;
   logic [DATA_W:0]   sub_res;
   logic              load_ok;
   state_t            fetch_state;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_wdata;

   assign ram_rd  = mem_q[mar_q];
   assign opcode  = ir_q[DATA_W-1 -: 4];
   assign operand = ir_q[ADDR_W-1:0];
   assign imm     = DATA_W'(operand);
   // SUB is A + ~M + 1, so the carry out reads as "no borrow".
   assign add_res = {1'b0, a_q} + {1'b0, ram_rd};
   assign sub_res = {1'b0, a_q} + {1'b0, ~ram_rd} + (DATA_W+1)'(1);
   assign load_ok = (state_q == S_IDLE) || (state_q == S_HALT);

`ifdef SAP_CORE_STEP_EN
   assign fetch_state = step_mode ? S_PAUSE : S_F1;
`else
   assign fetch_state = S_F1;
`endif

   // Host loads and STA share the single RAM write port; they never overlap in state.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = prog_addr;
      ram_wdata = prog_data;
      if (load_ok && prog_we) begin
         ram_we = 1'b1;
      end else if (state_q == S_E2 && opcode == OP_STA) begin
         ram_we    = 1'b1;
         ram_waddr = mar_q;
         ram_wdata = a_q;
      end
   end

   always_ff @(posedge clock) begin
      if (ram_we) mem_q[ram_waddr] <= ram_wdata;
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q     <= S_IDLE;
         pc_q        <= '0;
         mar_q       <= '0;
         ir_q        <= '0;
         a_q         <= '0;
         c_q         <= 1'b0;
         z_q         <= 1'b0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         case (state_q)
            S_IDLE, S_HALT: begin
               if (run) begin
                  pc_q     <= '0;
                  a_q      <= '0;
                  c_q      <= 1'b0;
                  z_q      <= 1'b0;
                  halted_q <= 1'b0;
                  state_q  <= S_F1;
               end
            end
            S_F1: begin
               mar_q   <= pc_q;
               state_q <= S_F2;
            end
            S_F2: begin
               ir_q    <= ram_rd;
               pc_q    <= pc_q + ADDR_W'(1);
               state_q <= S_E1;
            end
            S_E1: begin
               state_q <= fetch_state;
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     mar_q   <= operand;
                     state_q <= S_E2;
                  end
                  OP_LDI: a_q <= imm;
                  OP_JMP: pc_q <= operand;
                  OP_JC:  if (c_q) pc_q <= operand;
                  OP_JZ:  if (z_q) pc_q <= operand;
                  OP_OUT: begin
                     out_q       <= a_q;
                     out_valid_q <= 1'b1;
                  end
                  OP_HLT: begin
                     state_q  <= S_HALT;
                     halted_q <= 1'b1;
                  end
                  default: ;
               endcase
            end
            S_E2: begin
               state_q <= fetch_state;
               case (opcode)
                  OP_LDA: begin
                     a_q <= ram_rd;
                     z_q <= (ram_rd == '0);
                  end
                  OP_ADD: begin
                     a_q <= add_res[DATA_W-1:0];
                     c_q <= add_res[DATA_W];
                     z_q <= (add_res[DATA_W-1:0] == '0);
                  end
                  OP_SUB: begin
                     a_q <= sub_res[DATA_W-1:0];
                     c_q <= sub_res[DATA_W];
                     z_q <= (sub_res[DATA_W-1:0] == '0);
                  end
                  default: ;
               endcase
            end
`ifdef SAP_CORE_STEP_EN
            S_PAUSE: begin
               if (step) state_q <= S_F1;
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // out_valid is a one-cycle strobe with no back-pressure: a consumer must take out_data that cycle.
   assign out_data  = out_q;
   assign out_valid = out_valid_q;
   assign halted    = halted_q;
   assign pc_dbg    = pc_q;

endmodule

// File: tb/tb_sap_core_param.sv
// tb_sap_core_param: directed and random programs on an 8/4 and a 12/8 core,
// checked against an instruction-level reference model.
module tb_sap_core_param;

   localparam int W = 12;

   logic       clock = 1'b0;
   logic       clear;
   logic       run_s, we_s;
   logic [3:0] addr_s;
   logic [7:0] data_s;
   logic [7:0] out_s;
   logic       ov_s, halt_s;
   logic [3:0] pc_s;
   logic        run_w, we_w;
   logic [7:0]  addr_w;
   logic [11:0] data_w;
   logic [11:0] out_w;
   logic        ov_w, halt_w;
   logic [7:0]  pc_w;

   int n_checks = 0;
   int n_pass = 0;

   logic [W-1:0] exp_q[$];
   int exp_cyc_q[$];
   int exp_pc_q[$];
   int exp_start_q[$];
   int model_mem[256];
   int prog_mem[256];
   int m_halt_cyc, m_pc, m_a, m_c, m_z;
   bit m_ok;
   int got_v[$];
   int got_c[$];
   int pc_trace[2048];
   int halt_at;

   sap_core_param #(.DATA_W(8), .ADDR_W(4)) dut (
      .clock(clock), .clear(clear), .run(run_s), .prog_we(we_s),
      .prog_addr(addr_s), .prog_data(data_s),
`ifdef SAP_CORE_STEP_EN
      .step_mode(1'b0), .step(1'b0),
`endif
      .out_data(out_s), .out_valid(ov_s), .halted(halt_s), .pc_dbg(pc_s)
   );

   sap_core_param #(.DATA_W(12), .ADDR_W(8)) dut_w (
      .clock(clock), .clear(clear), .run(run_w), .prog_we(we_w),
      .prog_addr(addr_w), .prog_data(data_w),
`ifdef SAP_CORE_STEP_EN
      .step_mode(1'b0), .step(1'b0),
`endif
      .out_data(out_w), .out_valid(ov_w), .halted(halt_w), .pc_dbg(pc_w)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic int s_out(input bit wide);
      return wide ? int'(out_w) : int'(out_s);
   endfunction
   function automatic bit s_ov(input bit wide);
      return wide ? (ov_w === 1'b1) : (ov_s === 1'b1);
   endfunction
   function automatic bit s_halt(input bit wide);
      return wide ? (halt_w === 1'b1) : (halt_s === 1'b1);
   endfunction
   function automatic int s_pc(input bit wide);
      return wide ? int'(pc_w) : int'(pc_s);
   endfunction
   function automatic int get_mem(input bit wide, input int a);
      logic [3:0] an;
      logic [7:0] aw8;
      an  = a[3:0];
      aw8 = a[7:0];
      return wide ? int'(dut_w.mem_q[aw8]) : int'(dut.mem_q[an]);
   endfunction
   function automatic int get_a(input bit wide);
      return wide ? int'(dut_w.a_q) : int'(dut.a_q);
   endfunction
   function automatic int get_c(input bit wide);
      return wide ? int'(dut_w.c_q) : int'(dut.c_q);
   endfunction
   function automatic int get_z(input bit wide);
      return wide ? int'(dut_w.z_q) : int'(dut.z_q);
   endfunction

   task automatic drive_prog(input bit wide, input bit we, input int addr, input int data, input bit go);
      if (wide) begin
         we_w = we; addr_w = addr[7:0]; data_w = data[11:0]; run_w = go;
      end else begin
         we_s = we; addr_s = addr[3:0]; data_s = data[7:0]; run_s = go;
      end
   endtask

   // Instruction-level model: walks the program word by word, accumulating cycle counts.
   task automatic model_run(input int dw, input int aw);
      int dmask, amask, pc, a, c, z, cyc, w, op, opd, r;
      dmask = (1 << dw) - 1;
      amask = (1 << aw) - 1;
      pc = 0; a = 0; c = 0; z = 0; cyc = 1;
      exp_q.delete(); exp_cyc_q.delete(); exp_pc_q.delete(); exp_start_q.delete();
      m_ok = 1'b0;
      m_halt_cyc = 0;
      for (int n = 0; n < 300 && !m_ok; n++) begin
         exp_pc_q.push_back(pc);
         exp_start_q.push_back(cyc);
         w   = model_mem[pc];
         op  = (w >> (dw - 4)) & 15;
         opd = w & amask;
         pc  = (pc + 1) & amask;
         case (op)
            0: begin a = model_mem[opd]; z = (a == 0) ? 1 : 0; cyc += 4; end
            1: begin
               r = a + model_mem[opd];
               c = (r >> dw) & 1; a = r & dmask; z = (a == 0) ? 1 : 0; cyc += 4;
            end
            2: begin
               r = a + ((~model_mem[opd]) & dmask) + 1;
               c = (r >> dw) & 1; a = r & dmask; z = (a == 0) ? 1 : 0; cyc += 4;
            end
            3: begin model_mem[opd] = a; cyc += 4; end
            4: begin a = opd; cyc += 3; end
            5: begin pc = opd; cyc += 3; end
            6: begin if (c != 0) pc = opd; cyc += 3; end
            7: begin if (z != 0) pc = opd; cyc += 3; end
            14: begin exp_q.push_back(W'(a)); exp_cyc_q.push_back(cyc + 3); cyc += 3; end
            15: begin m_ok = 1'b1; m_halt_cyc = cyc + 3; end
            default: cyc += 3;
         endcase
      end
      m_pc = pc; m_a = a; m_c = c; m_z = z;
   endtask

   task automatic load_prog(input bit wide, input bit go_on_last);
      int depth;
      depth = wide ? 256 : 16;
      for (int i = 0; i < depth; i++) begin
         @(negedge clock);
         drive_prog(wide, 1'b1, i, prog_mem[i], go_on_last && (i == depth - 1));
      end
      @(negedge clock);
      drive_prog(wide, 1'b0, 0, 0, 1'b0);
   endtask

   // Runs prog_mem to HALT; the cycle after the run edge is cycle 1 (first F1).
   task automatic run_prog(input bit wide, input bit reload, input int inj_cyc,
                           input int inj_addr, input int inj_data);
      int depth, dw, aw, budget, diffs, n;
      bit halt_seen;
      dw = wide ? 12 : 8;
      aw = wide ? 8 : 4;
      depth = 1 << aw;
      for (int i = 0; i < 256; i++) model_mem[i] = prog_mem[i];
      model_run(dw, aw);
      if (inj_cyc < 0) inj_cyc = $urandom_range(1, m_halt_cyc - 1);
      if (reload) load_prog(wide, 1'b1);
      else begin
         @(negedge clock);
         drive_prog(wide, 1'b0, 0, 0, 1'b1);
         @(negedge clock);
         drive_prog(wide, 1'b0, 0, 0, 1'b0);
      end
      got_v.delete(); got_c.delete();
      halt_seen = 1'b0;
      halt_at = 0;
      budget = m_halt_cyc + 8;
      for (int k = 1; k <= budget && !halt_seen; k++) begin
         if (k > 1) @(negedge clock);
         if (k < 2048) pc_trace[k] = s_pc(wide);
         if (s_ov(wide)) begin got_v.push_back(s_out(wide)); got_c.push_back(k); end
         if (s_halt(wide)) begin halt_seen = 1'b1; halt_at = k; end
         else drive_prog(wide, k == inj_cyc, inj_addr, inj_data, 1'b0);
      end
      drive_prog(wide, 1'b0, 0, 0, 1'b0);
      check("halt_cycle", halt_at, m_halt_cyc);
      check("out_count", got_v.size(), exp_q.size());
      n = (got_v.size() < exp_q.size()) ? got_v.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check("out_value", got_v[i], int'(exp_q[i]));
         check("out_cycle", got_c[i], exp_cyc_q[i]);
      end
      for (int i = 0; i < exp_start_q.size(); i++)
         if (exp_start_q[i] < 2048 && exp_start_q[i] <= halt_at)
            check("pc_at_f1", pc_trace[exp_start_q[i]], exp_pc_q[i]);
      check("pc_halt", s_pc(wide), m_pc);
      check("acc", get_a(wide), m_a);
      check("carry", get_c(wide), m_c);
      check("zero", get_z(wide), m_z);
      diffs = 0;
      for (int i = 0; i < depth; i++) if (get_mem(wide, i) != model_mem[i]) diffs++;
      check("ram_diffs", diffs, 0);
   endtask

   task automatic gen_prog(input bit wide);
      int dw, aw, depth, r, op;
      dw = wide ? 12 : 8;
      aw = wide ? 8 : 4;
      depth = 1 << aw;
      for (int t = 0; t < 200; t++) begin
         for (int i = 0; i < 256; i++) prog_mem[i] = 0;
         for (int i = 0; i < depth; i++) begin
            r  = $urandom_range(0, 19);
            op = (r >= 16) ? 15 : r;
            if ($urandom_range(0, 3) == 0) prog_mem[i] = $urandom_range(0, (1 << dw) - 1);
            else prog_mem[i] = (op << (dw - 4)) | $urandom_range(0, depth - 1);
         end
         for (int i = 0; i < 256; i++) model_mem[i] = prog_mem[i];
         model_run(dw, aw);
         if (m_ok && m_halt_cyc > 6 && m_halt_cyc < 1500) return;
      end
      prog_mem[0] = 15 << (dw - 4);
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) prog_mem[i] = 0;
   endtask

   initial begin
      clear = 1'b0;
      drive_prog(1'b0, 1'b0, 0, 0, 1'b0);
      drive_prog(1'b1, 1'b0, 0, 0, 1'b0);
      repeat (3) @(negedge clock);
      check("rst_out", out_s, 0);
      check("rst_valid", ov_s, 0);
      check("rst_halted", halt_s, 0);
      check("rst_pc", pc_s, 0);
      check("rst_w_out", out_w, 0);
      check("rst_w_pc", pc_w, 0);
      clear = 1'b1;

      // arithmetic and output
      clear_prog();
      prog_mem[0] = 'h09; prog_mem[1] = 'h1A; prog_mem[2] = 'h2B; prog_mem[3] = 'hE0;
      prog_mem[4] = 'hF0; prog_mem[9] = 'h10; prog_mem[10] = 'h14; prog_mem[11] = 'h18;
      run_prog(1'b0, 1'b1, 0, 0, 0);
      check("arith_pulses", got_v.size(), 1);
      check("arith_out", (got_v.size() > 0) ? got_v[0] : -1, 'h0C);
      check("arith_halt", halt_at, 19);
      check("arith_c", get_c(1'b0), 1);
      check("arith_z", get_z(1'b0), 0);

      // carry/zero branch
      clear_prog();
      prog_mem[0] = 'h41; prog_mem[1] = 'h1F; prog_mem[2] = 'h77; prog_mem[3] = 'h67;
      prog_mem[4] = 'h4A; prog_mem[5] = 'hE0; prog_mem[6] = 'hF0; prog_mem[7] = 'hE0;
      prog_mem[8] = 'hF0; prog_mem[15] = 'hFF;
      run_prog(1'b0, 1'b1, 0, 0, 0);
      check("br_out", (got_v.size() > 0) ? got_v[0] : -1, 'h00);
      check("br_pc7", pc_trace[11], 7);
      check("br_a", get_a(1'b0), 0);
      check("br_c", get_c(1'b0), 1);
      check("br_z", get_z(1'b0), 1);

      // store round trip, with a host write attempted during the first E1
      clear_prog();
      prog_mem[0] = 'h45; prog_mem[1] = 'h3E; prog_mem[2] = 'h40; prog_mem[3] = 'h0E;
      prog_mem[4] = 'hE0; prog_mem[5] = 'hF0; prog_mem[12] = 'h5C; prog_mem[14] = 'h77;
      run_prog(1'b0, 1'b1, 3, 12, 'hAA);
      check("sta_ram", get_mem(1'b0, 14), 'h05);
      check("sta_out", (got_v.size() > 0) ? got_v[0] : -1, 'h05);
      check("lockout_ram", get_mem(1'b0, 12), 'h5C);

      // PC wrap through a NOP at the top address
      clear_prog();
      prog_mem[0] = 'h74; prog_mem[1] = 'h2D; prog_mem[2] = 'h5F; prog_mem[3] = 'hF0;
      prog_mem[4] = 'hE0; prog_mem[5] = 'hF0; prog_mem[15] = 'h80;
      run_prog(1'b0, 1'b1, 0, 0, 0);
      check("wrap_pc_f", pc_trace[11], 15);
      check("wrap_pc_0", pc_trace[13], 0);
      check("wrap_f1_0", pc_trace[14], 0);

      // clear during E2 of STA
      clear_prog();
      prog_mem[0] = 'h49; prog_mem[1] = 'hE0; prog_mem[2] = 'h3C; prog_mem[3] = 'hF0;
      prog_mem[12] = 'h33;
      load_prog(1'b0, 1'b1);
      repeat (9) @(negedge clock);
      check("pre_clr_out", out_s, 'h09);
      check("pre_clr_pc", pc_s, 3);
      clear = 1'b0;
      #1;
      check("clr_out", out_s, 0);
      check("clr_valid", ov_s, 0);
      check("clr_halted", halt_s, 0);
      check("clr_pc", pc_s, 0);
      @(negedge clock);
      clear = 1'b1;
      check("clr_no_sta", get_mem(1'b0, 12), 'h33);
      check("clr_keep0", get_mem(1'b0, 0), 'h49);
      check("clr_keep2", get_mem(1'b0, 2), 'h3C);
      run_prog(1'b0, 1'b0, 0, 0, 0);
      check("restart_out", (got_v.size() > 0) ? got_v[0] : -1, 'h09);
      check("restart_sta", get_mem(1'b0, 12), 'h09);

      // wide core: 0x800 + 0x800 and a wrap from 0xFF
      clear_prog();
      prog_mem[0] = 'h720; prog_mem[1] = 'h010; prog_mem[2] = 'h111; prog_mem[3] = 'h5FF;
      prog_mem['h10] = 'h800; prog_mem['h11] = 'h800; prog_mem['hFF] = 'h800;
      prog_mem['h20] = 'hE00; prog_mem['h21] = 'hF00;
      run_prog(1'b1, 1'b1, 0, 0, 0);
      check("w_a", get_a(1'b1), 0);
      check("w_c", get_c(1'b1), 1);
      check("w_z", get_z(1'b1), 1);
      check("w_pc_ff", pc_trace[15], 'hFF);
      check("w_pc_00", pc_trace[18], 0);
      check("w_halt", halt_at, 27);

      for (int t = 0; t < 25; t++) begin
         gen_prog(1'b0);
         run_prog(1'b0, 1'b1, -1, $urandom_range(0, 15), $urandom_range(0, 255));
      end
      for (int t = 0; t < 3; t++) begin
         gen_prog(1'b1);
         run_prog(1'b1, 1'b1, -1, $urandom_range(0, 255), $urandom_range(0, 4095));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sap_core_param.md
Name: sap_core_param

Overview:
- Parametrised successor to the SAP-1 datapath and controller, collapsed into one synthesizable core.
- Width-generic data path and address space.
- Extended instruction set with jumps, conditional branches, store and immediate load.
- Variable-length instruction cycles and a host program-load port.
- Sits at the top of the SAP tree; drives the output register seen by the bench.

Parameters:
DATA_W, 8, data/instruction word width; must satisfy DATA_W >= 4 + ADDR_W.
ADDR_W, 4, memory address width; RAM depth = 2^ADDR_W words.

Ports:
clock  input  1  system clock, rising edge.
clear  input  1  asynchronous reset, active-low.
run  input  1  start pulse; honoured only in IDLE or HALT.
prog_we  input  1  program write strobe; honoured only in IDLE or HALT.
prog_addr  input  ADDR_W  program write address.
prog_data  input  DATA_W  program write data.
out_data  output  DATA_W  output register (OUT instruction).
out_valid  output  1  one-cycle pulse when out_data is updated.
halted  output  1  high while in HALT.
pc_dbg  output  ADDR_W  current program counter.

Behaviour:
- Reset (clear=0, async): state=IDLE; PC, MAR, IR, A, C, Z, out_data = 0; out_valid=0; halted=0. RAM contents are not reset.
- RAM: 2^ADDR_W x DATA_W, combinational read at MAR, synchronous write.
- Program load: in IDLE/HALT, prog_we=1 writes prog_data to RAM[prog_addr] on the clock edge. In any other state prog_we is ignored.
- run accepted in IDLE/HALT:
  - PC=0, A=0, C=0, Z=0, halted=0; next state F1.
  - run and prog_we in the same cycle: the write completes before the first fetch.
- Instruction format: opcode = IR[DATA_W-1:DATA_W-4]; operand = IR[ADDR_W-1:0].
- Opcodes:
  - 0 LDA, 1 ADD, 2 SUB, 3 STA, 4 LDI (A = zero-extended operand), 5 JMP, 6 JC, 7 JZ, E OUT, F HLT.
  - 8-D are NOP.
- FSM states: IDLE, F1, F2, E1, E2, HALT.
  - F1: MAR <= PC.
  - F2: IR <= RAM[MAR]; PC <= PC+1, wrapping modulo 2^ADDR_W.
  - E1, memory ops (LDA/ADD/SUB/STA): MAR <= operand; go E2.
  - E1, LDI/JMP/NOP: execute, then go F1.
  - E1, JC/JZ: PC <= operand if C/Z set, else no change; go F1.
  - E1, OUT: out_data <= A; out_valid=1 in the following cycle only; go F1.
  - E1, HLT: go HALT, halted=1.
  - E2: LDA A <= RAM[MAR]; ADD A <= A+RAM[MAR]; SUB A <= A+~RAM[MAR]+1; STA RAM[MAR] <= A. Go F1.
- Instruction latency: memory ops 4 cycles; all others 3 cycles.
- Flags:
  - ADD/SUB compute in DATA_W+1 bits. C = bit DATA_W (SUB: C=1 means no borrow). Z = (result==0).
  - LDA updates Z only.
  - All other instructions leave C and Z unchanged.
- HALT: holds all registers. Exited only by run (restart) or by clear.
- Reset mid-instruction aborts immediately. Partially executed STA does not write if clear is low at the write edge.

Optional Feature:
- Macro: SAP_CORE_STEP_EN.
- Defined:
  - Adds input ports step_mode and step.
  - When step_mode=1, each instruction's final cycle transitions to a PAUSE state instead of F1.
  - PAUSE advances to F1 on the cycle step=1. prog_we is ignored in PAUSE.
  - step_mode=0 behaves as the free-running core.
  - pc_dbg is valid in PAUSE.
- Undefined: ports and PAUSE state are absent; the core is free-running only.

Test Plan:
- Arithmetic and output:
  - Load RAM 0:LDA 9, 1:ADD A, 2:SUB B, 3:OUT, 4:HLT; 9=0x10, A=0x14, B=0x18; pulse run.
  - Required: out_data=0x0C; out_valid high exactly once; halted=1 after 4+4+4+3+3=18 cycles from first F1; C=1, Z=0.
- Carry/zero branch:
  - Program: A=0x01, ADD of 0xFF, then JZ 7 and JC 7.
  - Required: A=0x00, C=1, Z=1; first branch taken; PC=7 after E1.
- Store round-trip:
  - Program: LDI 5, STA E, LDI 0, LDA E, OUT.
  - Required: RAM[E]=0x05; out_data=0x05.
- PC wrap:
  - JMP F with a NOP at address F.
  - Required: next F1 loads MAR=0; pc_dbg sequence F -> 0.
- Reset and load lockout:
  - prog_we asserted during E1 -> RAM unchanged.
  - clear low during E2 of STA -> outputs zero asynchronously, state IDLE, RAM[target] not written, program memory retained; run restarts at PC=0.
- Parameter sweep:
  - DATA_W=12, ADDR_W=8; ADD 0x800+0x800.
  - Required: A=0x000, C=1, Z=1; JMP 0xFF then wrap to 0x00.
